// File: rtl/ibus_wb_if.sv
// Instruction-fetch bridge: turns the core's single-cycle ROM fetch into a Wishbone B4 classic read,
// stalling the pipeline until the word arrives and holding it while IF/ID is frozen.
module ibus_wb_if #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  output logic        bus_err_o,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [31:0] adr_q;
  logic [31:0] rd_buf_q;
  logic        cyc_q;
  logic        err_q;
  logic [15:0] tmo_cnt_q;
  logic        timeout_hit;

  assign timeout_hit = (state_q == S_BUSY) && !wb_ack_i && (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      adr_q     <= 32'h0;
      rd_buf_q  <= 32'h0;
      cyc_q     <= 1'b0;
      err_q     <= 1'b0;
      tmo_cnt_q <= 16'h0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cpu_ce_i && !flush_i) begin
            adr_q     <= cpu_addr_i;
            cyc_q     <= 1'b1;
            tmo_cnt_q <= 16'h0;
            state_q   <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Flush wins over a same-cycle ack so a squashed fetch never reaches IF/ID.
          if (flush_i) begin
            cyc_q   <= 1'b0;
            state_q <= S_IDLE;
          end else if (wb_ack_i) begin
            cyc_q    <= 1'b0;
            rd_buf_q <= wb_dat_i;
            state_q  <= stall_i[1] ? S_WAIT : S_IDLE;
          end else if (timeout_hit) begin
            cyc_q    <= 1'b0;
            rd_buf_q <= 32'h0;
            err_q    <= 1'b1;
            state_q  <= stall_i[1] ? S_WAIT : S_IDLE;
          end else if (tmo_cnt_q != 16'hFFFF) begin
            tmo_cnt_q <= tmo_cnt_q + 16'h1;
          end
        end
        S_WAIT: begin
          if (!stall_i[1] || flush_i) state_q <= S_IDLE;
        end
        default: begin
          cyc_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign stallreq_o = cpu_ce_i && !flush_i &&
                      ((state_q == S_IDLE) ||
                       ((state_q == S_BUSY) && !wb_ack_i && !timeout_hit));

  always_comb begin
    cpu_data_o = 32'h0;
    if (cpu_ce_i) begin
      if ((state_q == S_BUSY) && wb_ack_i) cpu_data_o = wb_dat_i;
      else if (state_q == S_WAIT)          cpu_data_o = rd_buf_q;
    end
  end

  assign wb_adr_o  = adr_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = 1'b0;
  assign wb_sel_o  = 4'hF;
  assign bus_err_o = err_q;

endmodule

// File: tb/tb_ibus_wb_if.sv
// Bench for ibus_wb_if: a cycle-driven Wishbone slave, expected fetch words queued when the
// slave is programmed and popped when the bridge presents them to IF/ID.
module tb_ibus_wb_if;

  logic        clk;
  logic        rst;
  logic        cpu_ce_i;
  logic [31:0] cpu_addr_i;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic        bus_err_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;

  logic [31:0] exp_q[$];
  int          n_checks;
  int          n_errors;

  ibus_wb_if #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_ce_i   (cpu_ce_i),
    .cpu_addr_i (cpu_addr_i),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .cpu_data_o (cpu_data_o),
    .stallreq_o (stallreq_o),
    .bus_err_o  (bus_err_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_sel_o   (wb_sel_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // scoreboard: compare cpu_data_o against the oldest queued word
  task automatic sb_check(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got 0x%08h expected <empty queue>", tag, cpu_data_o);
    end else begin
      e = exp_q.pop_front();
      check(tag, cpu_data_o, e);
    end
  endtask

  // One complete fetch; called just after a rising edge, returns just after a rising edge.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] word,
                       input int waits, input int hold);
    int sr_cnt;
    int cyc_cnt;
    sr_cnt  = 0;
    cyc_cnt = 0;
    #1 cpu_ce_i = 1'b1; cpu_addr_i = addr; wb_ack_i = 1'b0; stall_i = 6'b0; flush_i = 1'b0;
    @(negedge clk);
    if (stallreq_o) sr_cnt++;
    check("req_cyc_low", 32'(wb_cyc_o), 32'd0);
    @(posedge clk);
    for (int w = 0; w < waits; w++) begin
      #1 cpu_addr_i = addr ^ 32'h0000_FFF0;
      @(negedge clk);
      if (stallreq_o) sr_cnt++;
      if (wb_cyc_o && wb_stb_o) cyc_cnt++;
      check("wait_adr", wb_adr_o, addr);
      @(posedge clk);
    end
    #1 wb_ack_i = 1'b1; wb_dat_i = word; stall_i = (hold > 0) ? 6'b000011 : 6'b0;
    exp_q.push_back(word);
    @(negedge clk);
    if (stallreq_o) sr_cnt++;
    if (wb_cyc_o && wb_stb_o) cyc_cnt++;
    check("ack_adr", wb_adr_o, addr);
    sb_check("ack_data");
    @(posedge clk);
    for (int k = 0; k < hold; k++) begin
      #1 wb_ack_i = 1'b0; wb_dat_i = 32'hDEAD_BEEF;
      exp_q.push_back(word);
      @(negedge clk);
      check("hold_cyc", 32'(wb_cyc_o), 32'd0);
      check("hold_stallreq", 32'(stallreq_o), 32'd0);
      sb_check("hold_data");
      @(posedge clk);
    end
    #1 wb_ack_i = 1'b0; stall_i = 6'b0; cpu_ce_i = 1'b0;
    @(negedge clk);
    check("done_cyc", 32'(wb_cyc_o), 32'd0);
    check("done_stb", 32'(wb_stb_o), 32'd0);
    check("done_data", cpu_data_o, 32'h0);
    check("done_stallreq", 32'(stallreq_o), 32'd0);
    @(posedge clk);
    check("stallreq_cycles", 32'(sr_cnt), 32'(waits + 1));
    check("cyc_cycles", 32'(cyc_cnt), 32'(waits + 1));
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b1; cpu_ce_i = 1'b0; cpu_addr_i = 32'h0; stall_i = 6'b0; flush_i = 1'b0;
    wb_dat_i = 32'h0; wb_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cyc", 32'(wb_cyc_o), 32'd0);
    check("rst_stb", 32'(wb_stb_o), 32'd0);
    check("rst_adr", wb_adr_o, 32'h0);
    check("rst_err", 32'(bus_err_o), 32'd0);
    check("rst_data", cpu_data_o, 32'h0);
    check("rst_stallreq", 32'(stallreq_o), 32'd0);
    check("we_const", 32'(wb_we_o), 32'd0);
    check("sel_const", 32'(wb_sel_o), 32'hF);
    @(posedge clk);

    // zero-wait, three wait states, then held by IF/ID stall
    fetch(32'h0000_0100, 32'h3401_1100, 0, 0);
    fetch(32'h0000_0104, 32'hA5A5_0104, 3, 0);
    fetch(32'h0000_0108, 32'h2000_0005, 0, 3);

    // flush in the second BUSY cycle together with ack
    #1 cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0200;
    @(negedge clk); check("fl_req", 32'(stallreq_o), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk); check("fl_busy_cyc", 32'(wb_cyc_o), 32'd1);
    @(posedge clk);
    #1 flush_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'h5555_AAAA;
    @(negedge clk); check("fl_stallreq", 32'(stallreq_o), 32'd0);
    @(posedge clk);
    #1 flush_i = 1'b0; wb_ack_i = 1'b0; cpu_addr_i = 32'h0000_0300;
    @(negedge clk);
    check("fl_cyc_low", 32'(wb_cyc_o), 32'd0);
    check("fl_stb_low", 32'(wb_stb_o), 32'd0);
    check("fl_data", cpu_data_o, 32'h0);
    check("fl_new_req", 32'(stallreq_o), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("fl_new_adr", wb_adr_o, 32'h0000_0300);
    check("fl_new_cyc", 32'(wb_cyc_o), 32'd1);
    @(posedge clk);
    #1 wb_ack_i = 1'b1; wb_dat_i = 32'h1234_5678; exp_q.push_back(32'h1234_5678);
    @(negedge clk); sb_check("fl_new_data");
    @(posedge clk);
    #1 wb_ack_i = 1'b0; cpu_ce_i = 1'b0;
    @(negedge clk); check("fl_end_cyc", 32'(wb_cyc_o), 32'd0);
    @(posedge clk);

    // timeout: slave never acks, 4 BUSY cycles
    #1 cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0400;
    @(negedge clk);
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      @(negedge clk);
      check("tmo_cyc", 32'(wb_cyc_o), 32'd1);
      check("tmo_err_low", 32'(bus_err_o), 32'd0);
      check("tmo_stallreq", 32'(stallreq_o), (i == 3) ? 32'd0 : 32'd1);
      if (i == 3) check("tmo_data", cpu_data_o, 32'h0);
      @(posedge clk);
    end
    #1 cpu_ce_i = 1'b0;
    @(negedge clk);
    check("tmo_cyc_drop", 32'(wb_cyc_o), 32'd0);
    check("tmo_err_pulse", 32'(bus_err_o), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk); check("tmo_err_end", 32'(bus_err_o), 32'd0);
    @(posedge clk);

    // asynchronous reset mid-BUSY
    #1 cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0500;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk); check("ar_busy_cyc", 32'(wb_cyc_o), 32'd1);
    #2 rst = 1'b1; cpu_ce_i = 1'b0;
    #1;
    check("ar_cyc", 32'(wb_cyc_o), 32'd0);
    check("ar_stb", 32'(wb_stb_o), 32'd0);
    check("ar_stallreq", 32'(stallreq_o), 32'd0);
    check("ar_adr", wb_adr_o, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); check("ar_idle_cyc", 32'(wb_cyc_o), 32'd0);
    @(posedge clk);
    fetch(32'h0000_0600, 32'hCAFE_0600, 1, 0);

    // randomised fetch mix
    for (int n = 0; n < 8; n++) begin
      fetch({20'h0, 10'($urandom_range(0, 1023)), 2'b00}, $urandom,
            $urandom_range(0, 2), $urandom_range(0, 2));
    end

    if (exp_q.size() != 0) check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
